// File: rtl/etroc2_readout_pkg.sv
// Shared word types, FSM encoding and frame field widths for the ETROC2 hit readout.
package etroc2_readout_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        DATA    = 2'd2,
        TRAILER = 2'd3
    } state_e;

    localparam logic [1:0] TYPE_HDR  = 2'b01;
    localparam logic [1:0] TYPE_DATA = 2'b10;
    localparam logic [1:0] TYPE_TRL  = 2'b11;

    localparam int BCID_W   = 12;
    localparam int L1ACNT_W = 8;
    localparam int HDR_W    = BCID_W + L1ACNT_W;
    // truncated flag and parity bit sit right below the hit count
    localparam int TRL_FLAG_W = 2;

endpackage

// File: rtl/frame_parity_acc.sv
// Clear/accumulate XOR reducer: folds each accepted word into a running parity bit.
module frame_parity_acc #(
    parameter int W = 30
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         acc_i,
    input  logic [W-1:0] din_i,
    output logic         parity_o
);

    logic par_q;
    logic par_d;

    always_comb begin
        par_d = par_q;
        if (clr_i) begin
            par_d = 1'b0;
        end else if (acc_i) begin
            par_d = par_q ^ (^din_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign parity_o = par_q;

endmodule

// File: rtl/hit_fifo_readout.sv
// Drains the pixel hit FIFO into one header/data/trailer frame per accepted L1A.
// Define FRAME_PARITY_EN to carry the frame XOR in the trailer parity bit.
module hit_fifo_readout
    import etroc2_readout_pkg::*;
#(
    parameter int HIT_WIDTH = 30,
    parameter int MAX_HITS  = 16,
    parameter int CNTW      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 l1a,
    input  logic [11:0]          bcid,
    input  logic                 fifoEmpty,
    input  logic [HIT_WIDTH-1:0] fifoData,
    output logic                 fifoRden,
    output logic [HIT_WIDTH+1:0] dout,
    output logic                 doutValid,
    input  logic                 doutReady,
    output logic                 busy,
    output logic [7:0]           droppedL1A
);

    localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_HITS);

    state_e               state_q;
    state_e               state_d;
    logic [HIT_WIDTH+1:0] dout_q;
    logic [HIT_WIDTH+1:0] dout_d;
    logic                 valid_q;
    logic                 valid_d;
    logic [BCID_W-1:0]    bcid_q;
    logic [BCID_W-1:0]    bcid_d;
    logic [L1ACNT_W-1:0]  l1a_cnt_q;
    logic [L1ACNT_W-1:0]  l1a_cnt_d;
    logic [CNTW-1:0]      hit_cnt_q;
    logic [CNTW-1:0]      hit_cnt_d;
    logic                 trunc_q;
    logic                 trunc_d;
    logic [7:0]           drop_q;
    logic [7:0]           drop_d;

    logic                 slot_free;
    logic                 is_busy;
    logic                 accept;
    logic                 ld_hdr;
    logic                 ld_data;
    logic                 ld_trl;
    logic                 end_empty;
    logic                 end_full;
    logic                 parity;
    logic [HIT_WIDTH-1:0] hdr_pl;
    logic [HIT_WIDTH-1:0] trl_pl;

    assign slot_free = !valid_q || doutReady;
    assign is_busy   = (state_q != IDLE) || valid_q;
    assign accept    = l1a && !is_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = HEADER;
            HEADER:  if (slot_free) state_d = DATA;
            DATA:    if (end_empty || end_full) state_d = TRAILER;
            TRAILER: if (slot_free) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_hdr    = 1'b0;
        ld_data   = 1'b0;
        ld_trl    = 1'b0;
        end_empty = 1'b0;
        end_full  = 1'b0;
        unique case (state_q)
            HEADER: ld_hdr = slot_free;
            DATA: begin
                end_empty = slot_free && fifoEmpty;
                end_full  = slot_free && !fifoEmpty && (hit_cnt_q == MAX_CNT);
                ld_data   = slot_free && !fifoEmpty && (hit_cnt_q < MAX_CNT);
            end
            TRAILER: ld_trl = slot_free;
            default: ;
        endcase
    end

    assign fifoRden = ld_data;

    // Header and trailer fields are MSB-aligned, zero-filled below
    always_comb begin
        hdr_pl = '0;
        hdr_pl[HIT_WIDTH-1 -: HDR_W] = {bcid_q, l1a_cnt_q};
    end

    always_comb begin
        trl_pl = '0;
        trl_pl[HIT_WIDTH-1 -: CNTW+TRL_FLAG_W] = {hit_cnt_q, trunc_q, parity};
    end

`ifdef FRAME_PARITY_EN
    logic [HIT_WIDTH-1:0] par_din;

    assign par_din = ld_hdr ? hdr_pl : fifoData;

    frame_parity_acc #(
        .W(HIT_WIDTH)
    ) u_parity (
        .clk_i   (clk),
        .rst_i   (reset),
        .clr_i   (accept),
        .acc_i   (ld_hdr || ld_data),
        .din_i   (par_din),
        .parity_o(parity)
    );
`else
    assign parity = 1'b0;
`endif

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        if (slot_free) begin
            valid_d = ld_hdr || ld_data || ld_trl;
        end
        unique case (1'b1)
            ld_hdr:  dout_d = {TYPE_HDR, hdr_pl};
            ld_data: dout_d = {TYPE_DATA, fifoData};
            ld_trl:  dout_d = {TYPE_TRL, trl_pl};
            default: ;
        endcase
    end

    always_comb begin
        bcid_d    = accept ? bcid : bcid_q;
        l1a_cnt_d = ld_hdr ? l1a_cnt_q + 1'b1 : l1a_cnt_q;
        hit_cnt_d = hit_cnt_q;
        if (accept) begin
            hit_cnt_d = '0;
        end else if (ld_data) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
        trunc_d = trunc_q;
        if (accept || end_empty) begin
            trunc_d = 1'b0;
        end else if (end_full) begin
            trunc_d = 1'b1;
        end
        drop_d = drop_q;
        if (l1a && is_busy && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            bcid_q    <= '0;
            l1a_cnt_q <= '0;
            hit_cnt_q <= '0;
            trunc_q   <= 1'b0;
            drop_q    <= '0;
        end else begin
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            bcid_q    <= bcid_d;
            l1a_cnt_q <= l1a_cnt_d;
            hit_cnt_q <= hit_cnt_d;
            trunc_q   <= trunc_d;
            drop_q    <= drop_d;
        end
    end

    assign dout       = dout_q;
    assign doutValid  = valid_q;
    assign busy       = is_busy;
    assign droppedL1A = drop_q;

endmodule

// File: tb/tb_hit_fifo_readout.sv
// Bench for hit_fifo_readout: frame-level model fed by a queue FIFO, directed and random traffic.
module tb_hit_fifo_readout;

    localparam int HW = 30;
    localparam int MH = 16;
    localparam int CW = 5;
    localparam int DW = HW + 2;
    localparam logic [DW-1:0] PM = 32'h0080_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          l1a;
    logic [11:0]   bcid;
    logic          fifoEmpty;
    logic [HW-1:0] fifoData;
    logic          fifoRden;
    logic [DW-1:0] dout;
    logic          doutValid;
    logic          doutReady;
    logic          busy;
    logic [7:0]    droppedL1A;

    always #5 clk = ~clk;

    hit_fifo_readout #(
        .HIT_WIDTH(HW),
        .MAX_HITS (MH),
        .CNTW     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .l1a       (l1a),
        .bcid      (bcid),
        .fifoEmpty (fifoEmpty),
        .fifoData  (fifoData),
        .fifoRden  (fifoRden),
        .dout      (dout),
        .doutValid (doutValid),
        .doutReady (doutReady),
        .busy      (busy),
        .droppedL1A(droppedL1A)
    );

    int checks = 0;
    int errors = 0;

    logic [HW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs[$];
    int            obs_step[$];
    logic [7:0]    m_l1a = '0;
    int            m_drop = 0;
    int            m_rem = 0;
    int            rden_cnt = 0;
    int            stepn = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_dout = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Whole expected frame from the FIFO contents at trigger time
    task automatic build_frame(input logic [11:0] b);
        int            n;
        logic          tr;
        logic          par;
        logic [HW-1:0] p;
        n  = (fq.size() > MH) ? MH : fq.size();
        tr = fq.size() > MH;
        p = '0;
        p[HW-1 -: 20] = {b, m_l1a};
        exp_q.push_back({2'b01, p});
        par = ^p;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({2'b10, fq[i]});
            par = par ^ (^fq[i]);
        end
`ifndef FRAME_PARITY_EN
        par = 1'b0;
`endif
        p = '0;
        p[HW-1 -: CW+2] = {CW'(n), tr, par};
        exp_q.push_back({2'b11, p});
        m_l1a = m_l1a + 8'd1;
        m_rem = fq.size() - n;
    endtask

    task automatic step(input logic l1a_v, input logic [11:0] bcid_v, input logic rdy_v);
        logic          was_busy;
        logic          rd;
        logic [DW-1:0] w;
        l1a       = l1a_v;
        bcid      = bcid_v;
        doutReady = rdy_v;
        fifoEmpty = (fq.size() == 0);
        fifoData  = fifoEmpty ? '0 : fq[0];
        #1;
        was_busy = exp_q.size() != 0;
        chk("busy", busy, was_busy);
        chk("dropped", droppedL1A, m_drop);
        if (hold_prev) begin
            chk("hold_valid", doutValid, 1'b1);
            chk("hold_dout", dout, prev_dout);
        end
        checks++;
        if (fifoRden && (fifoEmpty || (doutValid && !doutReady))) begin
            errors++;
            $display("FAIL rden_legal actual=1 required=0 empty=%0b valid=%0b", fifoEmpty, doutValid);
        end
        if (doutValid && doutReady) begin
            obs.push_back(dout);
            obs_step.push_back(stepn);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_word actual=%0h required=none", dout);
            end else begin
                w = exp_q.pop_front();
                checks--;
                chk("dout", dout, w);
                if (w[DW-1 -: 2] == 2'b11) chk("fifo_left", fq.size(), m_rem);
            end
        end
        rd = fifoRden;
        if (rd) rden_cnt++;
        if (l1a_v) begin
            if (was_busy) begin
                if (m_drop < 255) m_drop++;
            end else begin
                build_frame(bcid_v);
            end
        end
        hold_prev = doutValid && !doutReady;
        prev_dout = dout;
        if (rd && fq.size() != 0) void'(fq.pop_front());
        stepn++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_idle(input int maxn);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxn) begin
            step(1'b0, 12'h0, 1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout words_left=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic clr_obs();
        obs.delete();
        obs_step.delete();
        rden_cnt = 0;
    endtask

    task automatic push_hits(input int n);
        for (int i = 0; i < n; i++) fq.push_back(HW'($urandom));
    endtask

    initial begin
        int s0;
        int n;
        int st;
        int r0;
        int stall_rd;
        logic [HW-1:0] ha;
        logic [HW-1:0] hb;
        logic [HW-1:0] hc;

        reset     = 1'b1;
        l1a       = 1'b0;
        bcid      = '0;
        fifoEmpty = 1'b1;
        fifoData  = '0;
        doutReady = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", doutValid, 0);
        chk("rst_rden", fifoRden, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", droppedL1A, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // three hits, header latency and exact word values
        ha = 30'h1234567;
        hb = 30'h2ABCDEF;
        hc = 30'h0F0F0F0;
        fq.push_back(ha);
        fq.push_back(hb);
        fq.push_back(hc);
        clr_obs();
        s0 = stepn;
        step(1'b1, 12'h123, 1'b1);
        run_idle(100);
        chk("t1_words", obs.size(), 5);
        chk("t1_hdr", obs[0], 32'h448C_0000);
        chk("t1_lat", obs_step[0] - s0, 2);
        chk("t1_a", obs[1], {2'b10, ha});
        chk("t1_c", obs[3], {2'b10, hc});
        chk("t1_trl", obs[4] & ~PM, 32'hC600_0000);
        chk("t1_rden", rden_cnt, 3);

        // empty FIFO, second header carries count 1
        clr_obs();
        step(1'b1, 12'h456, 1'b1);
        run_idle(100);
        chk("t2_words", obs.size(), 2);
        chk("t2_hdr", obs[0], 32'h5158_0400);
        chk("t2_trl", obs[1] & ~PM, 32'hC000_0000);
        chk("t2_rden", rden_cnt, 0);

        // truncation at MAX_HITS with hits left over
        push_hits(20);
        clr_obs();
        step(1'b1, 12'h7FF, 1'b1);
        run_idle(200);
        chk("t3_words", obs.size(), 18);
        chk("t3_trl", obs[17] & ~PM, 32'hE100_0000);
        chk("t3_left", fq.size(), 4);
        clr_obs();
        step(1'b1, 12'h001, 1'b1);
        run_idle(100);
        chk("t3b_trl", obs[5] & ~PM, 32'hC800_0000);

        // exactly MAX_HITS is not truncated
        push_hits(16);
        clr_obs();
        step(1'b1, 12'h002, 1'b1);
        run_idle(200);
        chk("t3c_trl", obs[17] & ~PM, 32'hE000_0000);
        chk("t3c_left", fq.size(), 0);

        // backpressure after the second data word
        push_hits(6);
        clr_obs();
        step(1'b1, 12'h321, 1'b1);
        st = 0;
        stall_rd = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            if (obs.size() == 2 && st < 5) begin
                r0 = rden_cnt;
                step(1'b0, 12'h0, 1'b0);
                stall_rd += rden_cnt - r0;
                st++;
            end else begin
                step(1'b0, 12'h0, 1'b1);
            end
            n++;
        end
        run_idle(10);
        chk("t4_stall_rden", stall_rd, 0);
        chk("t4_words", obs.size(), 8);

        // l1a while busy
        push_hits(5);
        clr_obs();
        step(1'b1, 12'h0AA, 1'b1);
        step(1'b0, 12'h0, 1'b1);
        step(1'b1, 12'h0BB, 1'b1);
        step(1'b1, 12'h0CC, 1'b1);
        step(1'b0, 12'h0, 1'b1);
        step(1'b1, 12'h0DD, 1'b1);
        run_idle(100);
        chk("t5_words", obs.size(), 7);
        chk("t5_drop3", droppedL1A, 3);
        push_hits(2);
        step(1'b1, 12'h0EE, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 12'h0, 1'b0);
        chk("t5_sat", droppedL1A, 255);
        run_idle(100);

        // asynchronous reset mid-frame
        push_hits(10);
        clr_obs();
        step(1'b1, 12'h0F0, 1'b1);
        n = 0;
        while (obs.size() < 4 && n < 50) begin
            step(1'b0, 12'h0, 1'b1);
            n++;
        end
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", doutValid, 0);
        chk("ar_rden", fifoRden, 0);
        chk("ar_busy", busy, 0);
        chk("ar_dout", dout, 0);
        chk("ar_drop", droppedL1A, 0);
        exp_q.delete();
        m_l1a     = '0;
        m_drop    = 0;
        hold_prev = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clr_obs();
        step(1'b1, 12'hABC, 1'b1);
        run_idle(100);
        chk("ar_hdr", obs[0], 32'h6AF0_0000);
        chk("ar_drop0", droppedL1A, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if (exp_q.size() == 0 && $urandom_range(0, 3) == 0) push_hits($urandom_range(0, 20));
            step($urandom_range(0, 7) == 0, 12'($urandom), $urandom_range(0, 3) != 0);
        end
        run_idle(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_fifo_readout.md
Name: hit_fifo_readout

Overview:
- Downstream consumer of the pixel hit FIFO write/read controller in the ETROC2 readout chain.
- On each L1A it drains hits from the FIFO read side (fifoEmpty/fifoRden, data at the current read address).
- Emits one frame per L1A: header, up to MAX_HITS data words, trailer.
- The frame goes out on a registered valid/ready stream toward the serializer.

Parameters:
HIT_WIDTH, 30, hit payload width; must be >= 20
MAX_HITS, 16, maximum data words per frame
CNTW, 5, hit counter width; must be >= $clog2(MAX_HITS+1)

Ports:
clk  in  1  40 MHz readout clock, posedge
reset  in  1  asynchronous, active-high; clears all state
l1a  in  1  trigger pulse, sampled each posedge
bcid  in  12  bunch-crossing ID, captured when l1a is accepted
fifoEmpty  in  1  FIFO empty flag
fifoData  in  HIT_WIDTH  FIFO word at the current read address (fall-through)
fifoRden  out  1  pop strobe; one cycle high consumes exactly one word
dout  out  HIT_WIDTH+2  {type[1:0], payload}
doutValid  out  1  dout holds a valid word
doutReady  in  1  downstream accepts dout this cycle
busy  out  1  frame in progress or output register occupied
droppedL1A  out  8  count of l1a pulses ignored while busy

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous, active-high. While reset is high: state=IDLE; dout=0; doutValid=0; fifoRden=0; droppedL1A=0; l1aCount=0; hitCnt=0; parity=0.
- Type codes: 01 header, 10 data, 11 trailer.
- Header payload:
  - MSBs = {bcid_latched[11:0], l1aCount[7:0]}; rest 0.
  - l1aCount is an internal 8-bit counter: incremented when the header loads, wraps 255->0; header carries the pre-increment value.
- Data payload: fifoData unmodified.
- Trailer payload:
  - MSBs = {hitCnt[CNTW-1:0], truncated, parity}; rest 0.
- Output slot: slotFree = !doutValid || doutReady. dout is updated only when slotFree. doutValid falls when doutReady=1 and nothing new loads. dout is held stable while doutValid && !doutReady.
- FSM transitions:
  - IDLE: l1a=1 -> latch bcid, clear hitCnt, truncated and parity -> HEADER.
  - HEADER: on slotFree, load header -> DATA.
  - DATA, on slotFree:
    - fifoEmpty=1 -> TRAILER, truncated=0.
    - else if hitCnt==MAX_HITS -> TRAILER, truncated=1.
    - else fifoRden=1, load data word, hitCnt++.
  - TRAILER: on slotFree, load trailer -> IDLE.
- fifoRden:
  - Combinational: (state==DATA) && slotFree && !fifoEmpty && hitCnt<MAX_HITS.
  - Never asserted outside DATA.
- Latency: with doutReady held at 1, the header is valid 2 cycles after l1a is sampled; data words follow back-to-back, one per cycle.
- l1a while busy:
  - Ignored; the frame is unaffected.
  - droppedL1A increments, saturating at 255.
- l1a on the same cycle the FSM returns to IDLE counts as busy.
- FIFO emptying mid-frame ends the frame. Hits written later belong to the next L1A.
- busy = (state!=IDLE) || doutValid.

Optional Feature:
- Macro FRAME_PARITY_EN.
- Defined: parity = XOR of all header and data payload bits of the frame, accumulated as each word loads; inserted into the trailer parity bit.
- Undefined: trailer parity bit is constant 0 and no accumulator logic is instantiated.

Decomposition:
- etroc2_readout_pkg holds:
  - word type codes (TYPE_HDR, TYPE_DATA, TYPE_TRL)
  - state encoding (IDLE, HEADER, DATA, TRAILER)
  - header/trailer field widths and offsets (BCID_W=12, L1ACNT_W=8)
- One sub-module: frame_parity_acc, a clear/accumulate XOR reducer over HIT_WIDTH bits. Instantiated only under FRAME_PARITY_EN.

Test Plan:
- FIFO holds A,B,C; l1a with bcid=0x123; doutReady=1 -> header {01,0x123,0x00}, then data A,B,C, then trailer hitCnt=3, truncated=0; fifoRden high exactly 3 cycles.
- Empty FIFO; l1a -> header then trailer hitCnt=0; fifoRden never high; second l1a header carries l1aCount=1.
- 20 hits queued, MAX_HITS=16 -> 16 data words, trailer hitCnt=16, truncated=1; fifoEmpty remains 0 (4 words left).
- doutReady low for 5 cycles after the second data word -> dout/doutValid stable; fifoRden=0 throughout; no word lost or duplicated after release.
- l1a pulsed 3 times during a frame -> frame intact, droppedL1A=3. Force 300 drops -> droppedL1A=255.
- reset asserted asynchronously mid-DATA -> outputs clear without a clock edge. After release, l1a -> header l1aCount=0, droppedL1A=0. With FRAME_PARITY_EN defined, the trailer parity equals the reference XOR over the frame.
